// File: rtl/iob_uart_txfifo_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM encoding,
// default geometry and the post-issue guard length.
package iob_uart_txfifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GUARD = 2'd2
   } tx_state_t;

   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned DEPTH_LOG2_DEF = 4;

   // Cycles spent in GUARD so uart_core can drop tx_ready after a write.
   localparam int unsigned GUARD_LEN = 1;

endpackage

// File: rtl/iob_uart_txfifo_if.sv
// Bus bundle for iob_uart_txfifo: CPU push side, FIFO status and the
// uart_core transmit handshake. The FIFO uses the slave modport.
interface iob_uart_txfifo_if
   import iob_uart_txfifo_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);

   logic                  wr_en;
   logic [DATA_W-1:0]     wr_data;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  clr_overflow;
   logic                  core_tx_ready;
   logic                  core_wr_en;
   logic [DATA_W-1:0]     core_tx_data;

   modport master (
      output wr_en, wr_data, clr_overflow, core_tx_ready,
      input  full, empty, level, overflow, core_wr_en, core_tx_data
   );

   modport slave (
      input  wr_en, wr_data, clr_overflow, core_tx_ready,
      output full, empty, level, overflow, core_wr_en, core_tx_data
   );

endinterface

// File: rtl/iob_uart_fifo_mem.sv
// Generic synchronous FIFO core: register array, wrapping pointers and a
// separate occupancy counter. Push is ignored when full, pop when empty.
module iob_uart_fifo_mem
   import iob_uart_txfifo_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   output logic [DATA_W-1:0]     pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   // Status is decoded from the registered level, so a push in the same
   // cycle as a pop still sees full from before the edge.
   assign full     = (level == LVL_MAX);
   assign empty    = (level == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/iob_uart_txfifo.sv
// UART transmit buffer: queues CPU-written bytes and feeds them to
// uart_core one at a time via its tx_ready/data_write_en handshake.
// Optional feature: define UART_TXFIFO_THRESH_EN to add the thresh input
// and the registered below_thresh refill flag.
module iob_uart_txfifo
   import iob_uart_txfifo_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rst_soft,
   input  logic                  tx_en,
`ifdef UART_TXFIFO_THRESH_EN
   input  logic [DEPTH_LOG2:0]   thresh,
   output logic                  below_thresh,
`endif
   iob_uart_txfifo_if.slave      bus
);

   logic                  rst_any;
   tx_state_t             state;
   logic [1:0]            guard_cnt;
   logic                  pop;
   logic [DATA_W-1:0]     head;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  full_q;
   logic                  empty_q;
   logic [DATA_W-1:0]     tx_data_q;
   logic                  overflow_q;

   assign rst_any = rst || rst_soft;

   // Pop only from IDLE; the pop edge is also the IDLE->ISSUE edge.
   assign pop = (state == IDLE) && tx_en && !empty_q && bus.core_tx_ready;

   iob_uart_fifo_mem #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk       (clk),
      .rst       (rst_any),
      .push      (bus.wr_en),
      .push_data (bus.wr_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full_q),
      .empty     (empty_q),
      .level     (level_q)
   );

   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.core_wr_en   = (state == ISSUE);
   assign bus.core_tx_data = tx_data_q;

   // Issue FSM: latch the head byte on pop, pulse for one cycle, then
   // hold off GUARD_LEN cycles before another pop may be considered.
   always_ff @(posedge clk) begin
      if (rst_any) begin
         state     <= IDLE;
         guard_cnt <= '0;
         tx_data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state     <= ISSUE;
                  tx_data_q <= head;
               end
            end
            ISSUE: begin
               state     <= GUARD;
               guard_cnt <= '0;
            end
            GUARD: begin
               if (guard_cnt == 2'(GUARD_LEN - 1)) begin
                  state <= IDLE;
               end else begin
                  guard_cnt <= guard_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky drop flag; a dropped push outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst_any) begin
         overflow_q <= 1'b0;
      end else if (bus.wr_en && full_q) begin
         overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
         overflow_q <= 1'b0;
      end
   end

`ifdef UART_TXFIFO_THRESH_EN
   // Refill request flag, registered from the registered level.
   always_ff @(posedge clk) begin
      if (rst_any) begin
         below_thresh <= 1'b1;
      end else begin
         below_thresh <= (level_q < thresh);
      end
   end
`endif

endmodule

// File: tb/tb_iob_uart_txfifo.sv
// Self-checking bench for iob_uart_txfifo: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_iob_uart_txfifo;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   logic rst_soft;
   logic tx_en;
`ifdef UART_TXFIFO_THRESH_EN
   logic [4:0] thresh;
   logic       below_thresh;
`endif

   iob_uart_txfifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();

   iob_uart_txfifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .rst_soft     (rst_soft),
      .tx_en        (tx_en),
`ifdef UART_TXFIFO_THRESH_EN
      .thresh       (thresh),
      .below_thresh (below_thresh),
`endif
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  mq [$];
   int unsigned since_pop;
   logic [7:0]  m_data;
   logic        m_ovf;
   logic        m_below;
   bit          m_live = 1'b0;
   int          pre;
   bit          do_pop;
   int unsigned cyc = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst || rst_soft) begin
         mq.delete();
         since_pop = 2;
         m_data    = '0;
         m_ovf     = 1'b0;
         m_below   = 1'b1;
         m_live    = 1'b1;
      end else begin
         pre    = mq.size();
         do_pop = tx_en && (pre > 0) && bus.core_tx_ready && (since_pop >= 2);
`ifdef UART_TXFIFO_THRESH_EN
         m_below = (pre < int'(thresh));
`endif
         if (bus.wr_en && pre == DEPTH) m_ovf = 1'b1;
         else if (bus.clr_overflow)     m_ovf = 1'b0;
         if (do_pop) begin
            m_data    = mq.pop_front();
            since_pop = 0;
         end else if (since_pop < 2) begin
            since_pop = since_pop + 1;
         end
         if (bus.wr_en && pre < DEPTH) mq.push_back(bus.wr_data);
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_live) begin
         check("m_level",    32'(bus.level),        32'(mq.size()));
         check("m_empty",    32'(bus.empty),        32'(mq.size() == 0));
         check("m_full",     32'(bus.full),         32'(mq.size() == DEPTH));
         check("m_overflow", 32'(bus.overflow),     32'(m_ovf));
         check("m_wr_en",    32'(bus.core_wr_en),   32'(since_pop == 0));
         check("m_tx_data",  32'(bus.core_tx_data), 32'(m_data));
`ifdef UART_TXFIFO_THRESH_EN
         check("m_below",    32'(below_thresh),     32'(m_below));
`endif
      end
   end

   // ---------------- uart_core stand-in and monitor ----------------
   int unsigned core_hold = 0;
   int unsigned busy;
   logic [7:0]  recv [$];
   int unsigned pulse_cyc [$];

   always @(posedge clk) begin
      if (rst) begin
         bus.core_tx_ready <= 1'b1;
         busy              <= 0;
      end else if (bus.core_wr_en && core_hold != 0) begin
         bus.core_tx_ready <= 1'b0;
         busy              <= core_hold;
      end else if (busy > 1) begin
         busy <= busy - 1;
      end else if (busy == 1) begin
         busy              <= 0;
         bus.core_tx_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.core_wr_en) begin
         recv.push_back(bus.core_tx_data);
         pulse_cyc.push_back(cyc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_recv(input int unsigned n, input int unsigned budget);
      int unsigned c = 0;
      while (recv.size() < n && c < budget) begin
         step();
         c++;
      end
      check("wait_recv", 32'(recv.size()), 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst_soft = 1'b0; tx_en = 1'b0;
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr_overflow = 1'b0;
`ifdef UART_TXFIFO_THRESH_EN
      thresh = 5'd4;
`endif
      repeat (3) step();
      rst = 1'b0;

      // Reset then idle with transmit enabled and core ready.
      tx_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_empty", 32'(bus.empty), 32'd1);
         check("idle_level", 32'(bus.level), 32'd0);
         check("idle_wr_en", 32'(bus.core_wr_en), 32'd0);
      end
      step();

      // Single byte: pulse one cycle after the push edge.
      push(8'hA5);
      @(negedge clk);
      check("lat_wait",  32'(bus.core_wr_en), 32'd0);
      check("lat_lvl1",  32'(bus.level), 32'd1);
      @(negedge clk);
      check("lat_pulse", 32'(bus.core_wr_en), 32'd1);
      check("lat_data",  32'(bus.core_tx_data), 32'hA5);
      check("lat_lvl0",  32'(bus.level), 32'd0);
      repeat (5) step();
      check("single_cnt", 32'(recv.size()), 32'd1);
      if (recv.size() > 0) check("single_byte", 32'(recv[0]), 32'hA5);
      recv.delete(); pulse_cyc.delete();

      // Ordering and pacing against a slow core.
      core_hold = 40;
      for (int i = 1; i <= 5; i++) push(8'(i));
      wait_recv(5, 400);
      for (int i = 0; i < recv.size(); i++) begin
         check("pace_order", 32'(recv[i]), 32'(i + 1));
         if (i > 0) check("pace_gap", 32'(pulse_cyc[i] - pulse_cyc[i-1] >= 40), 32'd1);
      end
      core_hold = 0;
      repeat (45) step();
      recv.delete(); pulse_cyc.delete();

      // Overflow with transmit disabled.
      tx_en = 1'b0;
      for (int i = 0; i < 17; i++) begin
         push(8'(i));
         if (i == 15) begin
            @(negedge clk);
            check("ovf_full16", 32'(bus.full), 32'd1);
            check("ovf_ovf0",   32'(bus.overflow), 32'd0);
         end
      end
      @(negedge clk);
      check("ovf_set",   32'(bus.overflow), 32'd1);
      check("ovf_level", 32'(bus.level), 32'd16);
      bus.clr_overflow = 1'b1;
      push(8'h55);
      bus.clr_overflow = 1'b0;
      @(negedge clk);
      check("ovf_set_wins", 32'(bus.overflow), 32'd1);
      bus.clr_overflow = 1'b1;
      step();
      bus.clr_overflow = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 32'(bus.overflow), 32'd0);

      // Drain, then push across the pointer wrap while draining.
      tx_en = 1'b1;
      wait_recv(16, 200);
      for (int i = 0; i < recv.size() && i < 16; i++)
         check("drain_order", 32'(recv[i]), 32'(i));
      repeat (5) step();
      recv.delete(); pulse_cyc.delete();
      for (int i = 0; i < 20; i++) push(8'(8'h20 + i));
      wait_recv(20, 300);
      for (int i = 0; i < recv.size() && i < 20; i++)
         check("wrap_order", 32'(recv[i]), 32'(8'h20 + i));
      repeat (5) step();

      // Soft reset in the ISSUE cycle with three bytes left.
      tx_en = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
      tx_en = 1'b1;
      step();
      @(negedge clk);
      check("srst_issue", 32'(bus.core_wr_en), 32'd1);
      check("srst_lvl3",  32'(bus.level), 32'd3);
      rst_soft = 1'b1;
      step();
      rst_soft = 1'b0;
      @(negedge clk);
      check("srst_wr_en", 32'(bus.core_wr_en), 32'd0);
      check("srst_level", 32'(bus.level), 32'd0);
      check("srst_empty", 32'(bus.empty), 32'd1);
      check("srst_ovf",   32'(bus.overflow), 32'd0);
      check("srst_data",  32'(bus.core_tx_data), 32'd0);
      recv.delete();
      repeat (20) step();
      check("srst_quiet", 32'(recv.size()), 32'd0);

`ifdef UART_TXFIFO_THRESH_EN
      // Threshold flag around level 4 -> 3.
      begin
         bit seen = 1'b0;
         tx_en = 1'b0;
         for (int i = 0; i < 6; i++) push(8'(8'h70 + i));
         step();
         @(negedge clk);
         check("th_full6", 32'(below_thresh), 32'd0);
         tx_en = 1'b1;
         for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.level == 5'd3) begin
               seen = 1'b1;
               check("th_at3",   32'(below_thresh), 32'd0);
               @(negedge clk);
               check("th_after", 32'(below_thresh), 32'd1);
            end
         end
         check("th_seen", 32'(seen), 32'd1);
         step();
      end
`endif

      repeat (5) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iob_uart_txfifo.md
Name: iob_uart_txfifo

Overview:
- Transmit buffer placed directly upstream of uart_core's transmit side.
- Accepts bytes from the CPU register-file write strobe into a DEPTH-entry FIFO.
- Drains the FIFO into uart_core one byte at a time, using uart_core's tx_ready/data_write_en handshake.
- Lets software burst-write without polling UART_TXREADY per byte.

Parameters:
- DATA_W, 8, byte width pushed to uart_core tx_data.
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rst_soft  input  1  software reset (UART_SOFTRESET); synchronous, same effect as rst.
- tx_en  input  1  transmit enable (UART_TXEN); draining permitted only when 1.
- wr_en  input  1  CPU push strobe, one byte per cycle high.
- wr_data  input  DATA_W  byte to push.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was dropped.
- clr_overflow  input  1  clears overflow.
- core_tx_ready  input  1  uart_core tx_ready.
- core_wr_en  output  1  one-cycle pulse to uart_core data_write_en.
- core_tx_data  output  DATA_W  byte to uart_core tx_data; valid while core_wr_en=1.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. rst_soft acts identically.
- Reset values: full=0, empty=1, level=0, overflow=0, core_wr_en=0, core_tx_data=0. Pointers are 0 and the FSM is in IDLE. Memory contents are not reset.
- Storage: register array of DEPTH entries. wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH naturally. level is a separate counter.
- Push: when wr_en=1 and full=0 at the clock edge, write mem[wr_ptr] and increment wr_ptr. level reflects the push from the next cycle.
- Push while full: the byte is dropped, pointers are unchanged, and overflow<=1. This holds even if a pop happens in the same cycle, because full is evaluated on the pre-edge level.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- full and empty are decoded from the registered level (full = level==DEPTH, empty = level==0).
- FSM states: IDLE, ISSUE, GUARD.
  - IDLE -> ISSUE when tx_en=1, level!=0 and core_tx_ready=1. On this edge: core_tx_data<=mem[rd_ptr], rd_ptr++, level--.
  - ISSUE: core_wr_en=1 for exactly this one cycle (decoded from the state register). Next state is GUARD.
  - GUARD: one cycle so uart_core can drop tx_ready. Next state is IDLE.
- Minimum spacing between core_wr_en pulses is 3 cycles. Actual spacing is governed by core_tx_ready, i.e. the frame time.
- Latency: a byte pushed at edge N into an empty FIFO, with core ready, gives pop at edge N+1 and core_wr_en=1 during cycle N+1..N+2.
- tx_en dropping mid-ISSUE/GUARD: the current byte still completes. No new pop happens until tx_en=1.
- rst or rst_soft in ISSUE: core_wr_en goes low at the next edge. The in-flight byte is lost and the FIFO is emptied.
- clr_overflow together with a dropped push in the same cycle: set wins, so overflow=1.
- core_tx_data holds its last value between pulses.

Optional Feature:
- Macro UART_TXFIFO_THRESH_EN.
- When defined:
  - Adds input thresh [DEPTH_LOG2:0] and output below_thresh.
  - below_thresh is a registered flag, 1 when level < thresh (reset value 1). It is intended as an interrupt/poll source for refill.
- When undefined: neither port exists, and the behaviour is otherwise identical.

Decomposition:
- Shared package iob_uart_txfifo_pkg holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, GUARD=2'd2).
  - Default DEPTH_LOG2.
  - The GUARD length constant (1).
- One natural sub-module, iob_uart_fifo_mem: the pointer/level/array core with push/pop/full/empty. It is reusable later for an RX FIFO.
- The FSM and uart_core handshake stay in the top module.

Test Plan:
- Reset then idle: after rst, expect empty=1, level=0, core_wr_en=0 for 20 cycles with core_tx_ready=1 and tx_en=1.
- Single byte: push 0xA5 with core_tx_ready=1 and tx_en=1. Expect one core_wr_en pulse with core_tx_data=0xA5 one cycle after the push edge, then level=0.
- Ordering and pacing: push 0x01..0x05 back-to-back with a core model that holds tx_ready low 40 cycles after each write. Expect 5 pulses in order 0x01..0x05, with at least 40 cycles between them.
- Overflow and wrap: tx_en=0, push 17 bytes 0x00..0x10. Expect full=1 after 16 pushes, overflow=1, and 0x10 dropped. Then tx_en=1 drains 0x00..0x0F. Then push 20 more bytes while draining to exercise pointer wrap; the order must be preserved.
- Soft reset mid-transfer: assert rst_soft in the ISSUE cycle with level=3. Expect core_wr_en=0 next cycle, level=0, empty=1, overflow=0, and no further pulses.
- Threshold (with UART_TXFIFO_THRESH_EN): thresh=4. Push 6 bytes with tx_en=0; expect below_thresh=0. Drain; below_thresh rises the cycle after level becomes 3.
